// File: rtl/pwm_level_decoder.sv
// PWM receive decoder: measures period/high time of pwm_in and publishes level = floor(8*high/period).
// Optional macro PWM_DEC_FILTER_EN: a quotient is published only after two consecutive periods agree.
module pwm_level_decoder #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 50000,
    parameter int MIN_PERIOD = 4
) (
    input  logic             main_Clk50Mhz,
    input  logic             main_rst,
    input  logic             pwm_in,
    output logic [2:0]       level,
    output logic             valid,
    output logic             stuck,
    output logic [CNT_W-1:0] period_q,
    output logic [CNT_W-1:0] high_q
);

    typedef enum logic [1:0] {
        WAIT_EDGE = 2'd0,
        MEASURE   = 2'd1,
        DIVIDE    = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PERIOD);

    state_e           state_q, state_d;
    logic             sync_q, s_q, s_dly_q;
    logic             rise, timeout_hit;
    logic             accept, div_busy, div_done, publish;
    logic [1:0]       step_q, step_d;
    logic [CNT_W-1:0] p_cnt_q, p_cnt_d, h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] div_p_q, div_p_d, div_h_q, div_h_d;
    logic [CNT_W:0]   rem_q, rem_d, rem_sh, rem_sub;
    logic [1:0]       quo_q, quo_d;
    logic             quo_bit;
    logic [2:0]       quo_full;
    logic [CNT_W-1:0] idle_q, idle_d;
    logic [2:0]       level_q, level_d;
    logic             valid_q, valid_d, stuck_q, stuck_d;
    logic [CNT_W-1:0] out_period_q, out_period_d, out_high_q, out_high_d;

    assign rise        = s_q & ~s_dly_q;
    assign timeout_hit = ~rise & (idle_q == IDLE_LAST);

    // One restoring-division step per DIVIDE cycle; H < P keeps the quotient within 3 bits.
    assign rem_sh   = rem_q << 1;
    assign quo_bit  = (rem_sh >= {1'b0, div_p_q});
    assign rem_sub  = quo_bit ? (rem_sh - {1'b0, div_p_q}) : rem_sh;
    assign quo_full = {quo_q, quo_bit};

    // FSM: state register
    // NOTE: the asynchronous clear covers the synchronizer and the divider too, so a reset mid-DIVIDE drops the partial result at once.
    always_ff @(posedge main_Clk50Mhz or negedge main_rst) begin
        if (!main_rst) state_q <= WAIT_EDGE;
        else           state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_EDGE: if (rise) state_d = MEASURE;
            MEASURE:   if (rise && (p_cnt_q >= MIN_P)) state_d = DIVIDE;
            DIVIDE:    if (step_q == 2'd2) state_d = MEASURE;
            default:   state_d = WAIT_EDGE;
        endcase
        if (timeout_hit) state_d = WAIT_EDGE;
    end

    // FSM: control outputs
    always_comb begin
        accept   = 1'b0;
        div_busy = 1'b0;
        div_done = 1'b0;
        unique case (state_q)
            MEASURE: accept = rise && (p_cnt_q >= MIN_P);
            DIVIDE: begin
                div_busy = 1'b1;
                div_done = (step_q == 2'd2);
            end
            default: ;
        endcase
        if (timeout_hit) begin
            accept   = 1'b0;
            div_busy = 1'b0;
            div_done = 1'b0;
        end
    end

`ifdef PWM_DEC_FILTER_EN
    logic [2:0] cand_q, cand_d;
    logic       cand_vld_q, cand_vld_d;

    assign publish = div_done && cand_vld_q && (quo_full == cand_q);

    always_comb begin
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        if (div_done) begin
            cand_d     = quo_full;
            cand_vld_d = 1'b1;
        end
        // A stuck line starts agreement tracking afresh.
        if (timeout_hit) cand_vld_d = 1'b0;
    end

    always_ff @(posedge main_Clk50Mhz or negedge main_rst) begin
        if (!main_rst) begin
            cand_q     <= '0;
            cand_vld_q <= 1'b0;
        end else begin
            cand_q     <= cand_d;
            cand_vld_q <= cand_vld_d;
        end
    end
`else
    assign publish = div_done;
`endif

    // Datapath next-state
    // NOTE: every signal gets its default before any branch so no path infers a latch.
    always_comb begin
        p_cnt_d      = p_cnt_q;
        h_cnt_d      = h_cnt_q;
        div_p_d      = div_p_q;
        div_h_d      = div_h_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        step_d       = step_q;
        idle_d       = idle_q;
        level_d      = level_q;
        valid_d      = 1'b0;
        stuck_d      = stuck_q;
        out_period_d = out_period_q;
        out_high_d   = out_high_q;

        if (rise)                    idle_d = '0;
        else if (idle_q != IDLE_MAX) idle_d = idle_q + CNT_W'(1);

        if (timeout_hit || (state_q == WAIT_EDGE && !rise)) begin
            p_cnt_d = '0;
            h_cnt_d = '0;
        end else if (rise) begin
            p_cnt_d = CNT_W'(1);
            h_cnt_d = CNT_W'(1);
        end else begin
            if (p_cnt_q != CNT_MAX)        p_cnt_d = p_cnt_q + CNT_W'(1);
            if (s_q && h_cnt_q != CNT_MAX) h_cnt_d = h_cnt_q + CNT_W'(1);
        end

        if (accept) begin
            div_p_d = p_cnt_q;
            div_h_d = h_cnt_q;
            rem_d   = {1'b0, h_cnt_q};
            quo_d   = '0;
            step_d  = '0;
        end else if (div_busy) begin
            rem_d  = rem_sub;
            quo_d  = quo_full[1:0];
            step_d = step_q + 2'd1;
        end

        if (publish) begin
            level_d      = quo_full;
            out_period_d = div_p_q;
            out_high_d   = div_h_q;
            valid_d      = 1'b1;
        end

        if (timeout_hit) begin
            stuck_d = 1'b1;
            level_d = s_q ? 3'd7 : 3'd0;
            valid_d = 1'b1;
        end else if (rise) begin
            stuck_d = 1'b0;
        end
    end

    always_ff @(posedge main_Clk50Mhz or negedge main_rst) begin
        if (!main_rst) begin
            sync_q       <= 1'b0;
            s_q          <= 1'b0;
            s_dly_q      <= 1'b0;
            p_cnt_q      <= '0;
            h_cnt_q      <= '0;
            div_p_q      <= '0;
            div_h_q      <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            step_q       <= '0;
            idle_q       <= '0;
            level_q      <= '0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
            out_period_q <= '0;
            out_high_q   <= '0;
        end else begin
            sync_q       <= pwm_in;
            s_q          <= sync_q;
            s_dly_q      <= s_q;
            p_cnt_q      <= p_cnt_d;
            h_cnt_q      <= h_cnt_d;
            div_p_q      <= div_p_d;
            div_h_q      <= div_h_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            step_q       <= step_d;
            idle_q       <= idle_d;
            level_q      <= level_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
            out_period_q <= out_period_d;
            out_high_q   <= out_high_d;
        end
    end

    assign level    = level_q;
    assign valid    = valid_q;
    assign stuck    = stuck_q;
    assign period_q = out_period_q;
    assign high_q   = out_high_q;

endmodule

// File: tb/tb_pwm_level_decoder.sv
// Self-checking bench for pwm_level_decoder: scenario tasks plus a per-cycle comparison
// against a reference model that derives results from the recorded pin waveform.
module tb_pwm_level_decoder;

    localparam int CNT_W      = 16;
    localparam int TIMEOUT    = 1000;
    localparam int MIN_PERIOD = 4;
    localparam int MAXC       = 20000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pwm_in;
    logic [2:0]       level;
    logic             valid;
    logic             stuck;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_q;

    pwm_level_decoder #(
        .CNT_W     (CNT_W),
        .TIMEOUT   (TIMEOUT),
        .MIN_PERIOD(MIN_PERIOD)
    ) dut (
        .main_Clk50Mhz(clk),
        .main_rst     (rst_n),
        .pwm_in       (pwm_in),
        .level        (level),
        .valid        (valid),
        .stuck        (stuck),
        .period_q     (period_q),
        .high_q       (high_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit is_stuck;
        int lvl;
        int per;
        int hi;
    } ev_t;

    ev_t pending[$];
    bit  pin_hist[0:MAXC-1];
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    bit  in_reset = 1'b0;
    bit  armed = 1'b0;
    bit  stuck_fired = 1'b0;
    int  last_rise = 0;
    int  idle_base = 0;
    bit  exp_valid = 1'b0;
    bit  exp_stuck = 1'b0;
    int  exp_level = 0;
    int  exp_period = 0;
    int  exp_high = 0;
    int  valid_cnt = 0;
    int  last_valid_cyc = -1;

    // Reference model for posedge k. Pin value sampled at posedge j is pin_hist[j]; a pin
    // rise at posedge c is seen by the decoder at posedge c+2 and publishes 3 edges later.
    task automatic model_step(input int k);
        bit rise_seen;
        int p;
        int h;
        ev_t e;
        exp_valid = 1'b0;
        if (in_reset) begin
            exp_stuck  = 1'b0;
            exp_level  = 0;
            exp_period = 0;
            exp_high   = 0;
            return;
        end
        rise_seen = (k >= 3) && pin_hist[k-2] && !pin_hist[k-3];
        if (rise_seen) begin
            exp_stuck   = 1'b0;
            stuck_fired = 1'b0;
            idle_base   = k;
            if (armed) begin
                p = k - last_rise;
                if (p >= MIN_PERIOD) begin
                    h = 0;
                    for (int j = last_rise - 2; j < k - 2; j++) h += int'(pin_hist[j]);
                    e.cyc = k + 3; e.is_stuck = 1'b0; e.lvl = (8 * h) / p; e.per = p; e.hi = h;
                    pending.push_back(e);
                end
            end
            armed     = 1'b1;
            last_rise = k;
        end else if (!stuck_fired && (k - idle_base == TIMEOUT)) begin
            stuck_fired = 1'b1;
            armed       = 1'b0;
            e.cyc = k; e.is_stuck = 1'b1; e.lvl = pin_hist[k-2] ? 7 : 0; e.per = 0; e.hi = 0;
            pending.push_back(e);
        end
        while (pending.size() > 0 && pending[0].cyc == k) begin
            e = pending.pop_front();
            exp_valid = 1'b1;
            exp_level = e.lvl;
            if (e.is_stuck) begin
                exp_stuck = 1'b1;
            end else begin
                exp_period = e.per;
                exp_high   = e.hi;
            end
        end
    endtask

    // Drive one clock of pwm_in, then compare every output with the model at the falling edge.
    task automatic tick(input bit nxt);
        pwm_in = nxt;
        @(posedge clk);
        cyc++;
        if (cyc < MAXC) pin_hist[cyc] = nxt;
        @(negedge clk);
        model_step(cyc);
        if (valid === 1'b1) begin
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        checks++;
        if (valid !== exp_valid)
            $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, valid, exp_valid);
        if (valid !== exp_valid) failures++;
        checks++;
        if (stuck !== exp_stuck) begin
            failures++;
            $display("FAIL stuck cyc=%0d got=%b exp=%b", cyc, stuck, exp_stuck);
        end
        checks++;
        if (level !== 3'(exp_level)) begin
            failures++;
            $display("FAIL level cyc=%0d got=%0d exp=%0d", cyc, level, exp_level);
        end
        checks++;
        if (period_q !== CNT_W'(exp_period)) begin
            failures++;
            $display("FAIL period_q cyc=%0d got=%0d exp=%0d", cyc, period_q, exp_period);
        end
        checks++;
        if (high_q !== CNT_W'(exp_high)) begin
            failures++;
            $display("FAIL high_q cyc=%0d got=%0d exp=%0d", cyc, high_q, exp_high);
        end
    endtask

    task automatic drive_periods(input int per, input int hi, input int n);
        for (int r = 0; r < n; r++)
            for (int i = 0; i < per; i++) tick(i < hi);
    endtask

    // Asserts reset at a falling edge; outputs must clear without waiting for a clock.
    task automatic apply_reset(input int ncyc);
        rst_n    = 1'b0;
        pwm_in   = 1'b0;
        in_reset = 1'b1;
        pending.delete();
        #1;
        checks++;
        if ({level, valid, stuck, period_q, high_q} !== '0) begin
            failures++;
            $display("FAIL reset_async got level=%0d valid=%b stuck=%b period=%0d high=%0d exp all 0",
                     level, valid, stuck, period_q, high_q);
        end
        for (int i = 0; i < ncyc; i++) tick(1'b0);
        rst_n       = 1'b1;
        in_reset    = 1'b0;
        armed       = 1'b0;
        stuck_fired = 1'b0;
        idle_base   = cyc;
    endtask

    task automatic test_reset;
        apply_reset(4);
    endtask

    task automatic test_basic;
        int v0;
        int second_rise;
        int first_v;
        v0 = valid_cnt;
        second_rise = 0;
        first_v = -1;
        for (int n = 0; n < 6; n++) begin
            if (n == 1) second_rise = cyc + 1;
            for (int i = 0; i < 100; i++) begin
                tick(i < 50);
                if (valid === 1'b1 && first_v < 0) first_v = cyc;
            end
        end
        checks++;
        if (first_v !== second_rise + 5) begin
            failures++;
            $display("FAIL basic_first_valid got=%0d exp=%0d", first_v, second_rise + 5);
        end
        checks++;
        if (valid_cnt - v0 !== 5) begin
            failures++;
            $display("FAIL basic_valid_count got=%0d exp=5", valid_cnt - v0);
        end
        checks++;
        if (level !== 3'd4 || period_q !== 16'd100 || high_q !== 16'd50) begin
            failures++;
            $display("FAIL basic_result got level=%0d period=%0d high=%0d exp 4/100/50", level, period_q, high_q);
        end
    endtask

    task automatic test_levels;
        int his[3];
        int lvls[3];
        his[0] = 10; lvls[0] = 1;
        his[1] = 79; lvls[1] = 7;
        his[2] = 9;  lvls[2] = 0;
        for (int g = 0; g < 3; g++) begin
            drive_periods(80, his[g], 3);
            checks++;
            if (level !== 3'(lvls[g]) || high_q !== 16'(his[g]) || period_q !== 16'd80) begin
                failures++;
                $display("FAIL levels_high%0d got level=%0d high=%0d period=%0d exp level=%0d",
                         his[g], level, high_q, period_q, lvls[g]);
            end
        end
    endtask

    task automatic test_stuck;
        int v0;
        v0 = valid_cnt;
        for (int i = 0; i < TIMEOUT + 10; i++) tick(1'b1);
        checks++;
        if (stuck !== 1'b1 || level !== 3'd7 || period_q !== 16'd80) begin
            failures++;
            $display("FAIL stuck_high got stuck=%b level=%0d period=%0d exp 1/7/80", stuck, level, period_q);
        end
        checks++;
        if (valid_cnt - v0 !== 2) begin
            failures++;
            $display("FAIL stuck_valid_count got=%0d exp=2", valid_cnt - v0);
        end
        tick(1'b0);
        drive_periods(100, 25, 3);
        checks++;
        if (stuck !== 1'b0 || level !== 3'd2 || high_q !== 16'd25) begin
            failures++;
            $display("FAIL stuck_resume got stuck=%b level=%0d high=%0d exp 0/2/25", stuck, level, high_q);
        end
    endtask

    task automatic test_reject;
        int v0;
        for (int i = 0; i < TIMEOUT + 10; i++) tick(1'b0);
        checks++;
        if (stuck !== 1'b1 || level !== 3'd0) begin
            failures++;
            $display("FAIL reject_stuck_low got stuck=%b level=%0d exp 1/0", stuck, level);
        end
        v0 = valid_cnt;
        drive_periods(3, 1, 60);
        checks++;
        if (valid_cnt - v0 !== 0 || stuck !== 1'b0) begin
            failures++;
            $display("FAIL reject_short got valids=%0d stuck=%b exp 0/0", valid_cnt - v0, stuck);
        end
        v0 = valid_cnt;
        for (int i = 0; i < TIMEOUT + 10; i++) tick(1'b0);
        checks++;
        if (valid_cnt - v0 !== 1 || stuck !== 1'b1 || level !== 3'd0) begin
            failures++;
            $display("FAIL reject_timeout got valids=%0d stuck=%b level=%0d exp 1/1/0", valid_cnt - v0, stuck, level);
        end
    endtask

    task automatic test_reset_divide;
        int v0;
        drive_periods(100, 50, 1);
        for (int i = 0; i < 4; i++) tick(1'b1);
        apply_reset(4);
        v0 = valid_cnt;
        drive_periods(100, 50, 3);
        checks++;
        if (valid_cnt - v0 !== 2 || level !== 3'd4 || period_q !== 16'd100) begin
            failures++;
            $display("FAIL reset_divide got valids=%0d level=%0d period=%0d exp 2/4/100",
                     valid_cnt - v0, level, period_q);
        end
    endtask

    task automatic test_random;
        int v0;
        int exp_cnt;
        int pers[25];
        int his[25];
        v0 = valid_cnt;
        exp_cnt = 1;
        for (int n = 0; n < 25; n++) begin
            pers[n] = int'($urandom_range(2, 150));
            his[n]  = int'($urandom_range(1, pers[n] - 1));
            if (n < 24 && pers[n] >= MIN_PERIOD) exp_cnt++;
        end
        for (int n = 0; n < 25; n++) drive_periods(pers[n], his[n], 1);
        for (int i = 0; i < 10; i++) tick(1'b0);
        checks++;
        if (valid_cnt - v0 !== exp_cnt) begin
            failures++;
            $display("FAIL random_valid_count got=%0d exp=%0d", valid_cnt - v0, exp_cnt);
        end
    endtask

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b1;
        pwm_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_levels();
        test_stuck();
        test_reject();
        test_reset_divide();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
